// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational; updates from resolved branches land on the next clock edge.
module branch_target_buffer #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_PC,
  output logic        Pred_Taken,
  output logic [31:0] Pred_Target,
  input  logic        Upd_Valid,
  input  logic [31:0] Upd_PC,
  input  logic        Upd_Taken,
  input  logic [31:0] Upd_Target,
  output logic [15:0] Hit_Count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [15:0]      hit_cnt_q;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             if_hit;
  logic             upd_hit;
  logic             unused_pc_lsbs;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up && c != 2'b11)
      r = c + 2'b01;
    else if (!up && c != 2'b00)
      r = c - 2'b01;
    return r;
  endfunction

  function automatic logic [15:0] hit_inc(input logic [15:0] h);
    return (h == 16'hFFFF) ? h : h + 16'd1;
  endfunction

  // Instructions are word aligned, so the byte offset never participates.
  assign unused_pc_lsbs = ^{IF_PC[1:0], Upd_PC[1:0]};

  assign if_idx  = IF_PC[IDX_W+1:2];
  assign upd_idx = Upd_PC[IDX_W+1:2];
  assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == IF_PC[31:IDX_W+2]);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == Upd_PC[31:IDX_W+2]);

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    Pred_Taken  = if_hit && ctr_q[if_idx][1];
    Pred_Target = if_hit ? tgt_q[if_idx] : IF_PC + 32'd4;
  end

  assign Hit_Count = hit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= 32'd0;
        ctr_q[i]   <= 2'b01;
      end
      hit_cnt_q <= 16'd0;
    end else if (Upd_Valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], Upd_Taken);
        if (Upd_Taken)
          tgt_q[upd_idx] <= Upd_Target;
        hit_cnt_q <= hit_inc(hit_cnt_q);
      end else if (Upd_Taken) begin
        // Not-taken misses are never allocated: no target worth remembering.
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= Upd_PC[31:IDX_W+2];
        tgt_q[upd_idx]   <= Upd_Target;
        ctr_q[upd_idx]   <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: reference model feeding a scoreboard
// queue, plus directed checks on the documented scenarios and saturation limits.
module tb_branch_target_buffer;
  localparam int IW = 3;
  localparam int NE = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_PC;
  logic        Pred_Taken;
  logic [31:0] Pred_Target;
  logic        Upd_Valid;
  logic [31:0] Upd_PC;
  logic        Upd_Taken;
  logic [31:0] Upd_Target;
  logic [15:0] Hit_Count;

  branch_target_buffer #(.ENTRIES(NE)) dut (
    .clk(clk), .rst(rst), .IF_PC(IF_PC), .Pred_Taken(Pred_Taken),
    .Pred_Target(Pred_Target), .Upd_Valid(Upd_Valid), .Upd_PC(Upd_PC),
    .Upd_Taken(Upd_Taken), .Upd_Target(Upd_Target), .Hit_Count(Hit_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] tgt;
    logic [15:0] hc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic             m_v   [NE];
  logic [31-IW-2:0] m_tag [NE];
  logic [31:0]      m_t   [NE];
  logic [1:0]       m_c   [NE];
  logic [15:0]      m_hc;

  logic        s_pt;
  logic [31:0] s_tgt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NE; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_t[i] = 32'd0; m_c[i] = 2'b01;
    end
    m_hc = 16'd0;
  endfunction

  function automatic exp_t m_lookup(input logic [31:0] pc);
    exp_t e;
    int   i;
    logic h;
    i = int'(pc[IW+1:2]);
    h = m_v[i] && (m_tag[i] == pc[31:IW+2]);
    e.pt  = h && (m_c[i] >= 2'b10);
    e.tgt = h ? m_t[i] : pc + 32'd4;
    e.hc  = m_hc;
    return e;
  endfunction

  function automatic void m_upd(input logic r, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt);
    int   i;
    logic h;
    if (r) begin
      m_reset();
    end else if (uv) begin
      i = int'(upc[IW+1:2]);
      h = m_v[i] && (m_tag[i] == upc[31:IW+2]);
      if (h) begin
        if (m_hc != 16'hFFFF) m_hc = m_hc + 16'd1;
        if (ut) begin
          if (m_c[i] != 2'b11) m_c[i] = m_c[i] + 2'b01;
          m_t[i] = utgt;
        end else if (m_c[i] != 2'b00) begin
          m_c[i] = m_c[i] - 2'b01;
        end
      end else if (ut) begin
        m_v[i] = 1'b1; m_tag[i] = upc[31:IW+2]; m_t[i] = utgt; m_c[i] = 2'b10;
      end
    end
  endfunction

  // One clock: drive, check pre-edge lookup against the model, then apply the edge.
  task automatic cycle(input logic r, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic [31:0] ifpc);
    exp_t e;
    @(negedge clk);
    rst = r; Upd_Valid = uv; Upd_PC = upc; Upd_Taken = ut; Upd_Target = utgt; IF_PC = ifpc;
    sb.push_back(m_lookup(ifpc));
    #1;
    e = sb.pop_front();
    chk("sb_pred_taken", {31'd0, Pred_Taken}, {31'd0, e.pt});
    chk("sb_pred_target", Pred_Target, e.tgt);
    chk("sb_hit_count", {16'd0, Hit_Count}, {16'd0, e.hc});
    s_pt = Pred_Taken; s_tgt = Pred_Target;
    @(posedge clk);
    m_upd(r, uv, upc, ut, utgt);
  endtask

  task automatic peek(input string tag, input logic [31:0] ifpc, input logic ept,
                      input logic [31:0] etgt, input logic [15:0] ehc);
    @(negedge clk);
    rst = 1'b0; Upd_Valid = 1'b0; IF_PC = ifpc;
    #1;
    chk({tag, "_pt"}, {31'd0, Pred_Taken}, {31'd0, ept});
    chk({tag, "_tgt"}, Pred_Target, etgt);
    chk({tag, "_hc"}, {16'd0, Hit_Count}, {16'd0, ehc});
  endtask

  initial begin
    logic [31:0] pcs [6];
    pcs = '{32'h40, 32'h60, 32'h44, 32'h1C, 32'h1000_0044, 32'h80};
    rst = 1'b1; Upd_Valid = 1'b0; Upd_PC = '0; Upd_Taken = 1'b0; Upd_Target = '0;
    IF_PC = 32'h40;
    repeat (2) @(posedge clk);
    m_reset();

    peek("reset", 32'h40, 1'b0, 32'h44, 16'd0);

    cycle(0, 1, 32'h40, 1, 32'h100, 32'h40);
    peek("alloc", 32'h40, 1'b1, 32'h100, 16'd0);
    cycle(0, 1, 32'h40, 0, 32'hDEAD, 32'h40);
    peek("nt1", 32'h40, 1'b0, 32'h100, 16'd1);
    cycle(0, 1, 32'h40, 0, 32'hDEAD, 32'h40);
    peek("nt2", 32'h40, 1'b0, 32'h100, 16'd2);
    cycle(0, 1, 32'h40, 0, 32'hDEAD, 32'h40);
    peek("nt3_floor", 32'h40, 1'b0, 32'h100, 16'd3);
    cycle(0, 1, 32'h40, 1, 32'h104, 32'h40);
    peek("t_from_floor", 32'h40, 1'b0, 32'h104, 16'd4);

    cycle(0, 1, 32'h60, 1, 32'h200, 32'h60);
    peek("alias_old", 32'h40, 1'b0, 32'h44, 16'd4);
    peek("alias_new", 32'h60, 1'b1, 32'h200, 16'd4);

    cycle(0, 1, 32'h24, 0, 32'h999, 32'h24);
    peek("nt_miss", 32'h24, 1'b0, 32'h28, 16'd4);

    cycle(0, 1, 32'h80, 1, 32'h300, 32'h80);
    chk("same_cycle_pt", {31'd0, s_pt}, 32'd0);
    chk("same_cycle_tgt", s_tgt, 32'h84);
    peek("same_next", 32'h80, 1'b1, 32'h300, 16'd4);

    for (int k = 0; k < 3; k++) cycle(0, 1, 32'h80, 1, 32'h304, 32'h80);
    peek("ceiling", 32'h80, 1'b1, 32'h304, 16'd7);
    cycle(0, 1, 32'h80, 0, 32'h0, 32'h80);
    peek("from_ceiling", 32'h80, 1'b1, 32'h304, 16'd8);
    cycle(0, 1, 32'h80, 0, 32'h0, 32'h80);
    peek("weak_nt", 32'h80, 1'b0, 32'h304, 16'd9);

    cycle(0, 1, 32'h08, 1, 32'h500, 32'h08);
    peek("other_idx", 32'h08, 1'b1, 32'h500, 16'd9);
    peek("idx0_held", 32'h80, 1'b0, 32'h304, 16'd9);

    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
            pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), $urandom,
            pcs[$urandom_range(0, 5)]);
    end

    cycle(0, 1, 32'h08, 1, 32'h600, 32'h08);
    cycle(1, 1, 32'h08, 1, 32'h700, 32'h08);
    peek("rst_prio", 32'h08, 1'b0, 32'h0C, 16'd0);
    peek("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 16'd0);

    cycle(0, 1, 32'h40, 1, 32'h100, 32'h40);
    @(negedge clk);
    rst = 1'b0; Upd_Valid = 1'b1; Upd_PC = 32'h40; Upd_Taken = 1'b1; Upd_Target = 32'h100;
    IF_PC = 32'h40;
    repeat (65535) begin
      @(posedge clk);
      m_upd(0, 1, 32'h40, 1, 32'h100);
    end
    peek("hc_max", 32'h40, 1'b1, 32'h100, m_hc);
    chk("hc_max_abs", {16'd0, Hit_Count}, 32'h0000_FFFF);
    cycle(0, 1, 32'h40, 1, 32'h100, 32'h40);
    peek("hc_sat", 32'h40, 1'b1, 32'h100, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
